tc_program_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the shared 4-byte-wide program ROM (byte-addressed, 16-bit address, four consecutive bytes per read). It lets the instruction-fetch port (port 0) and the data-load port (port 1) share the single ROM read port. Requests are granted round-robin, one per cycle, and each read is tracked through a tag pipeline so every returned word reaches the port that issued it. It sits between the core's fetch/load units and the program ROM.

---
 rtl/tc_program_arb_pkg.sv | 17 +
 rtl/tc_program_arb_tagpipe.sv | 36 +++
 rtl/tc_program_arbiter.sv | 111 +++++++++++
 tb/tb_tc_program_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_program_arb_pkg.sv
// tc_program_arb_pkg
//   Shared constants and types for the two-port program ROM arbiter.
//   PORT_FETCH / PORT_LOAD : port identifiers carried in the tag pipeline
//   WORD_W                 : ROM read width (four bytes)
//   tag_t                  : {valid, port} marker travelling alongside a ROM read
package tc_program_arb_pkg;

    localparam logic        PORT_FETCH = 1'b0;
    localparam logic        PORT_LOAD  = 1'b1;
    localparam int unsigned WORD_W     = 32;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

// File: rtl/tc_program_arb_tagpipe.sv
// tc_program_arb_tagpipe
//   Fixed-depth shift register of read tags. A tag written at tag_in appears
//   at tag_out DEPTH cycles later. Synchronous clear invalidates every stage.
//   clk     in  clock
//   rst     in  synchronous active-high clear
//   tag_in  in  tag entering stage 0
//   tag_out out tag leaving the last stage
module tc_program_arb_tagpipe
    import tc_program_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/tc_program_arbiter.sv
// tc_program_arbiter
//   Round-robin arbiter sharing one program ROM read port between the
//   instruction-fetch port (0) and the data-load port (1). One grant per
//   cycle; each grant launches a registered ROM read and a tag that steers
//   the returned word back to the issuing port.
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           read requests (fetch / load)
//   addr0/addr1         byte addresses, held until acked
//   ack0/ack1           combinational grant for this cycle
//   rvalid0/rvalid1     one-cycle return strobes
//   rdata0/rdata1       returned words, byte at addr in [7:0]
//   mem_addr/mem_en     registered ROM address / read strobe
//   mem_rdata           ROM data, valid MEM_LATENCY cycles after mem_en
module tc_program_arbiter
    import tc_program_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [WORD_W-1:0] mem_rdata
);

    logic last;     // port granted most recently
    tag_t tag_in;
    tag_t tag_out;

    // Grant: a lone requester always wins; on contention the port not
    // granted last wins. Reset forces both grants low.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                ack0 = (last == PORT_LOAD);
                ack1 = (last == PORT_FETCH);
            end else begin
                ack0 = req0;
                ack1 = req1;
            end
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = ack0 | ack1;
        tag_in.port  = ack1 ? PORT_LOAD : PORT_FETCH;
    end

    // Issue side: register the granted address and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= PORT_LOAD;
            mem_addr <= '0;
            mem_en   <= 1'b0;
        end else begin
            mem_en <= ack0 | ack1;
            if (ack0) begin
                mem_addr <= addr0;
                last     <= PORT_FETCH;
            end else if (ack1) begin
                mem_addr <= addr1;
                last     <= PORT_LOAD;
            end
        end
    end

    // One stage per cycle from grant to ROM data valid: the address register
    // plus MEM_LATENCY ROM cycles.
    tc_program_arb_tagpipe #(
        .DEPTH(MEM_LATENCY + 1)
    ) u_tagpipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    // Return side: capture ROM data into the tagged port only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_out.valid && (tag_out.port == PORT_FETCH);
            rvalid1 <= tag_out.valid && (tag_out.port == PORT_LOAD);
            if (tag_out.valid && (tag_out.port == PORT_FETCH)) begin
                rdata0 <= mem_rdata;
            end
            if (tag_out.valid && (tag_out.port == PORT_LOAD)) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_tc_program_arbiter.sv
// tb_tc_program_arbiter
//   Drives two arbiter builds (MEM_LATENCY 1 and 3) with identical requests.
//   Each has its own ROM model; expected returns are queued per build at
//   grant time and matched against rvalid/rdata as they appear.
module tb_tc_program_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] addr0, addr1;

    logic        l1_ack0, l1_ack1, l1_rvalid0, l1_rvalid1, l1_mem_en;
    logic [31:0] l1_rdata0, l1_rdata1, l1_mem_rdata;
    logic [15:0] l1_mem_addr;
    logic        l3_ack0, l3_ack1, l3_rvalid0, l3_rvalid1, l3_mem_en;
    logic [31:0] l3_rdata0, l3_rdata1, l3_mem_rdata;
    logic [15:0] l3_mem_addr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int unsigned due;
    } entry_t;

    entry_t      q1[$];
    entry_t      q3[$];
    logic [31:0] held [2][2];
    logic        m_last;
    logic        g0, g1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tc_program_arbiter #(.MEM_LATENCY(1), .ADDR_W(16)) u_dut_l1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .ack0(l1_ack0), .ack1(l1_ack1), .rvalid0(l1_rvalid0), .rvalid1(l1_rvalid1),
        .rdata0(l1_rdata0), .rdata1(l1_rdata1), .mem_addr(l1_mem_addr),
        .mem_en(l1_mem_en), .mem_rdata(l1_mem_rdata)
    );

    tc_program_arbiter #(.MEM_LATENCY(3), .ADDR_W(16)) u_dut_l3 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .ack0(l3_ack0), .ack1(l3_ack1), .rvalid0(l3_rvalid0), .rvalid1(l3_rvalid1),
        .rdata0(l3_rdata0), .rdata1(l3_rdata1), .mem_addr(l3_mem_addr),
        .mem_en(l3_mem_en), .mem_rdata(l3_mem_rdata)
    );

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
    endfunction

    // ROM models: data valid MEM_LATENCY cycles after mem_addr/mem_en.
    logic [31:0] p1;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p1    <= l1_mem_en ? rom_word(l1_mem_addr) : 32'hDEAD_BEEF;
        p3[0] <= l3_mem_en ? rom_word(l3_mem_addr) : 32'hDEAD_BEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign l1_mem_rdata = p1;
    assign l3_mem_rdata = p3[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Return-path monitor for one build (idx 0 = latency 1, 1 = latency 3).
    task automatic mon(input int idx, input logic rv0, input logic rv1,
                       input logic [31:0] d0, input logic [31:0] d1);
        entry_t e;
        bit     have;
        string  nm;
        nm   = (idx == 0) ? "L1" : "L3";
        have = 1'b0;
        if (idx == 0) begin
            if (q1.size() != 0) begin have = 1'b1; e = q1[0]; end
        end else begin
            if (q3.size() != 0) begin have = 1'b1; e = q3[0]; end
        end
        if (rv0 || rv1) begin
            if (!have) begin
                check_eq({nm, "_unexpected_rvalid"}, {30'd0, rv1, rv0}, 32'd0);
            end else begin
                if (idx == 0) void'(q1.pop_front()); else void'(q3.pop_front());
                check_eq({nm, "_rvalid_port"}, {30'd0, rv1, rv0}, e.port ? 32'd2 : 32'd1);
                check_eq({nm, "_rvalid_cycle"}, cyc, e.due);
                check_eq({nm, "_rdata"}, e.port ? d1 : d0, e.data);
                check_eq({nm, "_rdata_other_held"}, e.port ? d0 : d1, held[idx][!e.port]);
                held[idx][e.port] = e.data;
            end
        end else if (have && cyc > e.due) begin
            check_eq({nm, "_rvalid_timeout"}, cyc, e.due);
            if (idx == 0) void'(q1.pop_front()); else void'(q3.pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, l1_rvalid0, l1_rvalid1, l1_rdata0, l1_rdata1);
        mon(1, l3_rvalid0, l3_rvalid1, l3_rdata0, l3_rdata1);
    end

    // One arbitration cycle: drive, check grants, queue expected returns,
    // then check the registered ROM strobe/address.
    task automatic step(input logic r0, input logic r1,
                        input logic [15:0] a0, input logic [15:0] a1,
                        output logic og0, output logic og1);
        logic [15:0] ga;
        entry_t      e;
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        #1;
        og0 = 1'b0;
        og1 = 1'b0;
        if (r0 && r1) begin
            if (m_last) og0 = 1'b1; else og1 = 1'b1;
        end else begin
            og0 = r0;
            og1 = r1;
        end
        check_eq("L1_ack0", {31'd0, l1_ack0}, {31'd0, og0});
        check_eq("L1_ack1", {31'd0, l1_ack1}, {31'd0, og1});
        check_eq("L3_ack0", {31'd0, l3_ack0}, {31'd0, og0});
        check_eq("L3_ack1", {31'd0, l3_ack1}, {31'd0, og1});
        ga = og0 ? a0 : a1;
        if (og0 || og1) begin
            e.port = og1;
            e.data = rom_word(ga);
            e.due  = cyc + 3;
            q1.push_back(e);
            e.due  = cyc + 5;
            q3.push_back(e);
            m_last = og1;
        end
        @(posedge clk);
        #1;
        check_eq("L1_mem_en", {31'd0, l1_mem_en}, {31'd0, og0 | og1});
        check_eq("L3_mem_en", {31'd0, l3_mem_en}, {31'd0, og0 | og1});
        if (og0 || og1) begin
            check_eq("L1_mem_addr", {16'd0, l1_mem_addr}, {16'd0, ga});
            check_eq("L3_mem_addr", {16'd0, l3_mem_addr}, {16'd0, ga});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, g0, g1);
    endtask

    // Reset with both requests held high; grants must stay low and every
    // output must read zero after the reset edge.
    task automatic do_reset(input int n);
        rst  = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        q1.delete();
        q3.delete();
        for (int p = 0; p < 2; p++) begin
            held[0][p] = '0;
            held[1][p] = '0;
        end
        m_last = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_eq("rst_acks", {28'd0, l1_ack0, l1_ack1, l3_ack0, l3_ack1}, 32'd0);
            @(posedge clk);
            #1;
            check_eq("rst_L1_ctl", {28'd0, l1_rvalid0, l1_rvalid1, l1_mem_en, 1'b0}, 32'd0);
            check_eq("rst_L3_ctl", {28'd0, l3_rvalid0, l3_rvalid1, l3_mem_en, 1'b0}, 32'd0);
            check_eq("rst_L1_mem_addr", {16'd0, l1_mem_addr}, 32'd0);
            check_eq("rst_L3_mem_addr", {16'd0, l3_mem_addr}, 32'd0);
            check_eq("rst_L1_rdata", l1_rdata0 | l1_rdata1, 32'd0);
            check_eq("rst_L3_rdata", l3_rdata0 | l3_rdata1, 32'd0);
            @(negedge clk);
        end
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic        pend0, pend1;
        logic [15:0] pa0, pa1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        m_last = 1'b1;
        @(negedge clk);
        do_reset(2);

        // Single fetch read.
        step(1'b1, 1'b0, 16'h0010, 16'h0000, g0, g1);
        idle(6);

        // Load port alone, back-to-back.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000, 16'(i * 4), g0, g1);
        idle(6);

        // Continuous contention.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'h0100, 16'h0200, g0, g1);
        idle(6);

        // Address wrap.
        step(1'b1, 1'b0, 16'hFFFE, 16'h0000, g0, g1);
        idle(6);

        // Two reads in flight, then reset: no returns, port 0 wins next.
        step(1'b1, 1'b0, 16'h0040, 16'h0000, g0, g1);
        step(1'b0, 1'b1, 16'h0000, 16'h0080, g0, g1);
        do_reset(2);
        step(1'b1, 1'b1, 16'h0300, 16'h0400, g0, g1);
        check_eq("post_reset_winner", {31'd0, g0}, 32'd1);
        idle(6);

        // Four back-to-back fetches: all in flight in the latency-3 build.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h1000 + 16'(i * 3), 16'h0000, g0, g1);
        idle(8);

        // Random mix; an unacked request keeps its address.
        pend0 = 1'b0; pend1 = 1'b0; pa0 = '0; pa1 = '0;
        for (int i = 0; i < 60; i++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin pend0 = 1'b1; pa0 = 16'($urandom); end
            if (!pend1 && $urandom_range(0, 2) != 0) begin pend1 = 1'b1; pa1 = 16'($urandom); end
            step(pend0, pend1, pa0, pa1, g0, g1);
            if (g0) pend0 = 1'b0;
            if (g1) pend1 = 1'b0;
        end
        idle(8);

        check_eq("L1_drain", q1.size(), 32'd0);
        check_eq("L3_drain", q3.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
